// File: rtl/round_robin_arbiter_n.sv
// N-client bus arbiter with rotating or strict priority. A grant is held until
// server_ack or an acknowledge timeout, then released with optional back-to-back regrant.
module round_robin_arbiter_n #(
    parameter int NUMBER_OF_CLIENTS = 4,
    parameter int ADDR_WIDTH        = 2,
    parameter int ACK_TIMEOUT       = 16,
    parameter int TO_CNT_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         mode,
    input  logic [NUMBER_OF_CLIENTS-1:0] client_rq,
    input  logic [NUMBER_OF_CLIENTS-1:0] client_mask,
    input  logic                         server_ack,
    output logic [NUMBER_OF_CLIENTS-1:0] grant,
    output logic [ADDR_WIDTH-1:0]        address_to_be_served,
    output logic                         grant_valid,
    output logic                         timeout_pulse
);
    localparam int N  = NUMBER_OF_CLIENTS;
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q;
    logic [N-1:0]            grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [TO_CNT_WIDTH-1:0] cnt_q;
    logic                    pulse_q;

    logic [N-1:0]            elig;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic [ADDR_WIDTH-1:0]   scan_base;
    logic [IW-1:0]           idx;
    logic [ADDR_WIDTH-1:0]   win_idx;
    logic                    win_found;
    logic [N-1:0]            win_oh;
    logic                    ack_release;
    logic                    to_release;
    logic                    rel_any;

    // (base + k) mod N, with base < N and k < N
    function automatic logic [IW-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        elig      = client_rq & ~client_mask;
        addr_inc  = (addr_q == ADDR_WIDTH'(N - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        scan_base = (state_q == IDLE) ? ptr_q : addr_inc;
        if (mode) scan_base = '0;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        // Scan downward so the closest eligible client to the base wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = wrap_add(scan_base, k);
            if (elig[idx]) begin
                win_found = 1'b1;
                win_idx   = ADDR_WIDTH'(idx);
            end
        end
        win_oh      = N'(1) << win_idx;
        ack_release = (state_q == GRANT) && server_ack;
        to_release  = (state_q == GRANT) && !server_ack && (ACK_TIMEOUT > 0) &&
                      (cnt_q == TO_CNT_WIDTH'(ACK_TIMEOUT - 1));
        rel_any     = ack_release || to_release;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && win_found) begin
                        state_q <= GRANT;
                        grant_q <= win_oh;
                        addr_q  <= win_idx;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (rel_any) begin
                        ptr_q   <= addr_inc;
                        pulse_q <= to_release;
                        cnt_q   <= '0;
                        if (enable && win_found) begin
                            grant_q <= win_oh;
                            addr_q  <= win_idx;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (ACK_TIMEOUT > 0) begin
                        cnt_q <= cnt_q + TO_CNT_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant                = grant_q;
    assign address_to_be_served = addr_q;
    assign grant_valid          = (state_q == GRANT);
    assign timeout_pulse        = pulse_q;

endmodule
